// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types and constants for the instruction-fetch sequencer
package fetch_ctrl_pkg;
    localparam logic [63:0] PCINIT = 64'h8000_0000;
    localparam int ILEN_DEF = 32;
    localparam logic [63:0] PC_STEP_DEF = 64'd4;
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} fetch_state_t;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;
    typedef struct packed {
        logic                addr_ok;
        logic                data_ok;
        logic [ILEN_DEF-1:0] data;
    } ibus_resp_t;
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction bus valid/addr_ok/data_ok handshake bundle
interface fetch_ctrl_if
    import fetch_ctrl_pkg::*;
#(parameter int ILEN = ILEN_DEF);
    logic            ireq_valid;
    logic [63:0]     ireq_addr;
    logic            iresp_addr_ok;
    logic            iresp_data_ok;
    logic [ILEN-1:0] iresp_data;
    modport master (
        output ireq_valid, ireq_addr,
        input  iresp_addr_ok, iresp_data_ok, iresp_data
    );
    modport slave (
        input  ireq_valid, ireq_addr,
        output iresp_addr_ok, iresp_data_ok, iresp_data
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: pc owner, ibus request sequencer, instruction buffer and redirect/drop handling
module fetch_ctrl #(
    parameter logic [63:0] PCINIT  = fetch_ctrl_pkg::PCINIT,
    parameter int          ILEN    = fetch_ctrl_pkg::ILEN_DEF,
    parameter logic [63:0] PC_STEP = fetch_ctrl_pkg::PC_STEP_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stallF,
    input  logic            redirect_valid,
    input  logic [63:0]     redirect_pc,
    fetch_ctrl_if.master    ibus,
    output logic [63:0]     pc_o,
    output logic [ILEN-1:0] raw_instr_o,
    output logic            instr_valid_o
);
    import fetch_ctrl_pkg::*;
    fetch_state_t state;
    logic [63:0] pc, tgt;
    logic drop, pend;
    logic [ILEN-1:0] instr_q;
    logic aok, dok;
    always_comb begin
        aok = ibus.iresp_addr_ok;
        dok = ibus.iresp_data_ok;
        ibus.ireq_valid = state == S_REQ && !reset;
        ibus.ireq_addr = ibus.ireq_valid ? pc : '0;
        instr_valid_o = state == S_HOLD;
        pc_o = instr_valid_o ? pc : '0;
        raw_instr_o = instr_valid_o ? instr_q : '0;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= S_REQ;
            pc <= PCINIT;
            tgt <= '0;
            drop <= 1'b0;
            pend <= 1'b0;
            instr_q <= '0;
        end else if (state == S_REQ) begin
            if (redirect_valid && !aok) begin
                pend <= 1'b1;
                tgt <= redirect_pc;
            end else if (redirect_valid || (aok && pend)) begin
                pc <= redirect_valid ? redirect_pc : tgt;
                pend <= 1'b0;
                drop <= !dok;
                state <= dok ? S_REQ : S_WAIT;
            end else if (aok) begin
                instr_q <= dok ? ibus.iresp_data : instr_q;
                state <= dok ? S_HOLD : S_WAIT;
            end
        end else if (state == S_WAIT) begin
            if (redirect_valid) begin
                pc <= redirect_pc;
                drop <= !dok;
                state <= dok ? S_REQ : S_WAIT;
            end else if (dok) begin
                drop <= 1'b0;
                instr_q <= drop ? instr_q : ibus.iresp_data;
                state <= drop ? S_REQ : S_HOLD;
            end
        end else if (redirect_valid || !stallF) begin
            pc <= redirect_valid ? redirect_pc : pc + PC_STEP;
            state <= S_REQ;
        end
    a_no_stray_data: assert property (@(posedge clk) disable iff (reset) dok |-> state != S_HOLD);
    a_redirect_align: assert property (@(posedge clk) disable iff (reset) redirect_valid |-> redirect_pc[1:0] == 2'b00);
    a_no_valid_drop: assert property (@(posedge clk) disable iff (reset) !(instr_valid_o && drop));
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: table-driven directed checks of the fetch sequencer plus async reset sequences
module tb_fetch_ctrl;
    typedef struct packed {
        logic [2:0]  ctl;
        logic [63:0] rpc;
        logic [1:0]  ok;
        logic [31:0] dat;
        logic        ev;
        logic [63:0] ea;
        logic        iv;
        logic [63:0] epc;
        logic [31:0] eraw;
    } vec_t;
    localparam logic [63:0] Z = '0;
    localparam logic [31:0] Z32 = '0;
    localparam logic [63:0] A0 = 64'h8000_0000;
    localparam logic [63:0] A4 = 64'h8000_0004;
    localparam logic [63:0] A8 = 64'h8000_0008;
    localparam logic [63:0] AC = 64'h8000_000C;
    localparam logic [63:0] B = 64'h8000_1000;
    localparam logic [63:0] B4 = 64'h8000_1004;
    localparam logic [63:0] C = 64'h8000_2000;
    localparam logic [63:0] E = 64'h0000_0000_0000_0100;
    localparam logic [63:0] F = 64'h0000_0000_0000_0200;
    localparam logic [63:0] W = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [31:0] DX = 32'hDEAD_BEEF;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0 = 32'h1111_0001;
    localparam logic [31:0] I1 = 32'h2222_0002;
    localparam logic [31:0] I2 = 32'h3333_0003;
    localparam logic [31:0] I3 = 32'h4444_0004;
    localparam logic [31:0] I4 = 32'h5555_0005;
    localparam logic [31:0] I5 = 32'h6666_0006;
    localparam logic [31:0] I6 = 32'h7777_0007;
    localparam logic [31:0] I7 = 32'h8888_0008;
    localparam logic [31:0] I8 = 32'h9999_0009;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stallF = 1'b0;
    logic redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic [63:0] pc_o;
    logic [31:0] raw_instr_o;
    logic instr_valid_o;
    int n_assert = 0;
    int n_fail = 0;
    vec_t v[$];
    fetch_ctrl_if #(.ILEN(32)) ibus();
    fetch_ctrl dut (
        .clk(clk),
        .reset(reset),
        .stallF(stallF),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .ibus(ibus),
        .pc_o(pc_o),
        .raw_instr_o(raw_instr_o),
        .instr_valid_o(instr_valid_o)
    );
    always #5 clk = ~clk;
    function automatic vec_t mk(input logic [2:0] ctl, input logic [63:0] rpc, input logic [1:0] ok,
                                input logic [31:0] dat, input logic ev, input logic [63:0] ea,
                                input logic iv, input logic [63:0] epc, input logic [31:0] eraw);
        mk = '{ctl, rpc, ok, dat, ev, ea, iv, epc, eraw};
    endfunction
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        n_assert++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask
    task automatic drive(input logic r, input logic s, input logic rv, input logic [63:0] rp,
                         input logic a, input logic d, input logic [31:0] dt);
        reset = r;
        stallF = s;
        redirect_valid = rv;
        redirect_pc = rp;
        ibus.iresp_addr_ok = a;
        ibus.iresp_data_ok = d;
        ibus.iresp_data = dt;
    endtask
    initial begin
        drive(1'b1, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z32);
        // ctl = {reset, stallF, redirect_valid}, ok = {addr_ok, data_ok}
        // zero-wait bus, one instruction every two cycles
        v.push_back(mk(3'b100, Z, 2'b00, Z32, 1'b0, Z,  1'b0, Z,  Z32));
        v.push_back(mk(3'b000, Z, 2'b11, I0,  1'b1, A0, 1'b0, Z,  Z32));
        v.push_back(mk(3'b000, Z, 2'b00, Z32, 1'b0, Z,  1'b1, A0, I0));
        v.push_back(mk(3'b000, Z, 2'b11, I1,  1'b1, A4, 1'b0, Z,  Z32));
        v.push_back(mk(3'b000, Z, 2'b00, Z32, 1'b0, Z,  1'b1, A4, I1));
        v.push_back(mk(3'b000, Z, 2'b11, I2,  1'b1, A8, 1'b0, Z,  Z32));
        v.push_back(mk(3'b000, Z, 2'b00, Z32, 1'b0, Z,  1'b1, A8, I2));
        v.push_back(mk(3'b000, Z, 2'b00, Z32, 1'b1, AC, 1'b0, Z,  Z32));
        // addr_ok then data_ok three cycles later
        v.push_back(mk(3'b100, Z, 2'b00, Z32, 1'b0, Z,  1'b0, Z,  Z32));
        v.push_back(mk(3'b000, Z, 2'b10, Z32, 1'b1, A0, 1'b0, Z,  Z32));
        v.push_back(mk(3'b000, Z, 2'b00, Z32, 1'b0, Z,  1'b0, Z,  Z32));
        v.push_back(mk(3'b000, Z, 2'b00, Z32, 1'b0, Z,  1'b0, Z,  Z32));
        v.push_back(mk(3'b000, Z, 2'b01, NOP, 1'b0, Z,  1'b0, Z,  Z32));
        // four stall cycles in hold, then release
        v.push_back(mk(3'b010, Z, 2'b00, Z32, 1'b0, Z,  1'b1, A0, NOP));
        v.push_back(mk(3'b010, Z, 2'b00, Z32, 1'b0, Z,  1'b1, A0, NOP));
        v.push_back(mk(3'b010, Z, 2'b00, Z32, 1'b0, Z,  1'b1, A0, NOP));
        v.push_back(mk(3'b010, Z, 2'b00, Z32, 1'b0, Z,  1'b1, A0, NOP));
        v.push_back(mk(3'b000, Z, 2'b00, Z32, 1'b0, Z,  1'b1, A0, NOP));
        // redirect while waiting for data; response dropped
        v.push_back(mk(3'b000, Z, 2'b10, Z32, 1'b1, A4, 1'b0, Z,  Z32));
        v.push_back(mk(3'b001, B, 2'b00, Z32, 1'b0, Z,  1'b0, Z,  Z32));
        v.push_back(mk(3'b000, Z, 2'b01, DX,  1'b0, Z,  1'b0, Z,  Z32));
        v.push_back(mk(3'b000, Z, 2'b11, I3,  1'b1, B,  1'b0, Z,  Z32));
        v.push_back(mk(3'b000, Z, 2'b00, Z32, 1'b0, Z,  1'b1, B,  I3));
        // redirect and data_ok in the same waiting cycle
        v.push_back(mk(3'b000, Z, 2'b10, Z32, 1'b1, B4, 1'b0, Z,  Z32));
        v.push_back(mk(3'b001, C, 2'b01, DX,  1'b0, Z,  1'b0, Z,  Z32));
        // redirect during request with addr_ok low two cycles
        v.push_back(mk(3'b001, B, 2'b00, Z32, 1'b1, C,  1'b0, Z,  Z32));
        v.push_back(mk(3'b000, Z, 2'b00, Z32, 1'b1, C,  1'b0, Z,  Z32));
        v.push_back(mk(3'b000, Z, 2'b10, Z32, 1'b1, C,  1'b0, Z,  Z32));
        v.push_back(mk(3'b000, Z, 2'b01, DX,  1'b0, Z,  1'b0, Z,  Z32));
        v.push_back(mk(3'b000, Z, 2'b11, I4,  1'b1, B,  1'b0, Z,  Z32));
        // redirect wins over a consume in the same cycle
        v.push_back(mk(3'b001, E, 2'b00, Z32, 1'b0, Z,  1'b1, B,  I4));
        // pending redirect resolved by a zero-wait response, discarded at once
        v.push_back(mk(3'b001, F, 2'b00, Z32, 1'b1, E,  1'b0, Z,  Z32));
        v.push_back(mk(3'b000, Z, 2'b11, DX,  1'b1, E,  1'b0, Z,  Z32));
        v.push_back(mk(3'b000, Z, 2'b11, I5,  1'b1, F,  1'b0, Z,  Z32));
        // redirect under stall, then pc wrap-around
        v.push_back(mk(3'b011, W, 2'b00, Z32, 1'b0, Z,  1'b1, F,  I5));
        v.push_back(mk(3'b000, Z, 2'b11, I6,  1'b1, W,  1'b0, Z,  Z32));
        v.push_back(mk(3'b000, Z, 2'b00, Z32, 1'b0, Z,  1'b1, W,  I6));
        v.push_back(mk(3'b000, Z, 2'b11, I7,  1'b1, Z,  1'b0, Z,  Z32));
        for (int i = 0; i < v.size(); i++) begin
            @(negedge clk);
            drive(v[i].ctl[2], v[i].ctl[1], v[i].ctl[0], v[i].rpc, v[i].ok[1], v[i].ok[0], v[i].dat);
            #1;
            chk($sformatf("v%0d ireq_valid", i), {63'd0, ibus.ireq_valid}, {63'd0, v[i].ev});
            chk($sformatf("v%0d ireq_addr", i), ibus.ireq_addr, v[i].ea);
            chk($sformatf("v%0d instr_valid_o", i), {63'd0, instr_valid_o}, {63'd0, v[i].iv});
            chk($sformatf("v%0d pc_o", i), pc_o, v[i].epc);
            chk($sformatf("v%0d raw_instr_o", i), {32'd0, raw_instr_o}, {32'd0, v[i].eraw});
        end
        // async reset while holding an instruction clears outputs before any clock edge
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, Z, 1'b0, 1'b0, Z32);
        #1;
        chk("hold before reset instr_valid_o", {63'd0, instr_valid_o}, 64'd1);
        chk("hold before reset raw_instr_o", {32'd0, raw_instr_o}, {32'd0, I7});
        #1 reset = 1'b1;
        #1;
        chk("async reset instr_valid_o", {63'd0, instr_valid_o}, 64'd0);
        chk("async reset raw_instr_o", {32'd0, raw_instr_o}, 64'd0);
        chk("async reset ireq_valid", {63'd0, ibus.ireq_valid}, 64'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, Z, 1'b1, 1'b0, Z32);
        #1;
        chk("post reset ireq_valid", {63'd0, ibus.ireq_valid}, 64'd1);
        chk("post reset ireq_addr", ibus.ireq_addr, A0);
        // reset in the middle of a wait; the late data_ok must be ignored
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z32);
        #1;
        chk("wait ireq_valid", {63'd0, ibus.ireq_valid}, 64'd0);
        #2 reset = 1'b1;
        #1;
        chk("wait reset ireq_valid", {63'd0, ibus.ireq_valid}, 64'd0);
        chk("wait reset instr_valid_o", {63'd0, instr_valid_o}, 64'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, Z, 1'b0, 1'b1, DX);
        #1;
        chk("after wait reset ireq_addr", ibus.ireq_addr, A0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, Z, 1'b1, 1'b1, I8);
        #1;
        chk("late data_ok instr_valid_o", {63'd0, instr_valid_o}, 64'd0);
        chk("late data_ok ireq_valid", {63'd0, ibus.ireq_valid}, 64'd1);
        chk("late data_ok ireq_addr", ibus.ireq_addr, A0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z32);
        #1;
        chk("refetch instr_valid_o", {63'd0, instr_valid_o}, 64'd1);
        chk("refetch pc_o", pc_o, A0);
        chk("refetch raw_instr_o", {32'd0, raw_instr_o}, {32'd0, I8});
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
